// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong game blocks.
//   - game_state_e : encoding of the game-state FSM output consumed by the
//                    ball motion controller.
//   - motion_state_e : internal sequencing states of ball_motion_ctrl.
//   - P1_BOARD_X / P2_BOARD_X : paddle face x coordinates, shared so goal
//                    detection and ball reflection use the same geometry.
package pingpong_pkg;

  typedef enum logic [1:0] {
    P1_SERVE = 2'd0,
    P2_SERVE = 2'd1,
    PLAYING  = 2'd2,
    GAME_END = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    SERVE1 = 2'd0,
    SERVE2 = 2'd1,
    MOVING = 2'd2,
    FROZEN = 2'd3
  } motion_state_e;

  localparam logic [9:0] P1_BOARD_X = 10'd150;
  localparam logic [9:0] P2_BOARD_X = 10'd490;

endpackage

// File: rtl/paddle_hit_detect.sv
// Combinational vertical overlap test between the ball and one paddle.
// Ports:
//   y        : candidate ball y (already wall-clamped)
//   paddle_y : top edge of the paddle
//   in_range : 1 when paddle_y <= y <= paddle_y + PADDLE_H - 1
module paddle_hit_detect #(
  parameter logic [9:0] PADDLE_H = 10'd60
) (
  input  logic [9:0] y,
  input  logic [9:0] paddle_y,
  output logic       in_range
);

  // Bottom edge is formed in 11 bits so a paddle near the bottom of the
  // coordinate range cannot wrap its span back to small y values.
  logic [10:0] bottom;

  assign bottom   = {1'b0, paddle_y} + {1'b0, PADDLE_H} - 11'd1;
  assign in_range = (y >= paddle_y) && ({1'b0, y} <= bottom);

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position sequencer for the ping-pong game.
// Tracks the serving paddle while a serve is pending, launches the ball when
// play starts, and advances it one step per frame tick while playing,
// reflecting off the walls and the paddles and speeding up every few hits.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   game_state            : 0=p1 serve, 1=p2 serve, 2=playing, 3=game end
//   tick                  : one-cycle frame strobe
//   p1_paddle_y/p2_paddle_y : top y of each paddle
//   ball_x, ball_y        : ball position
//   ball_dx, ball_dy      : direction (dx=1 right, dy=1 down)
//   speed                 : pixels per tick per axis
//   hit_count             : paddle hits since the last serve (saturating)
//   paddle_hit            : one-cycle pulse after a paddle reflection
module ball_motion_ctrl
  import pingpong_pkg::*;
#(
  parameter logic [9:0] WALL_TOP         = 10'd40,
  parameter logic [9:0] WALL_BOTTOM      = 10'd440,
  parameter logic [9:0] PADDLE_H         = 10'd60,
  parameter logic [2:0] SPEED_INIT       = 3'd1,
  parameter logic [2:0] SPEED_MAX        = 3'd6,
  parameter logic [3:0] HITS_PER_SPEEDUP = 4'd4,
  parameter logic [9:0] X_LIMIT          = 10'd639
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] game_state,
  input  logic       tick,
  input  logic [9:0] p1_paddle_y,
  input  logic [9:0] p2_paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_dx,
  output logic       ball_dy,
  output logic [2:0] speed,
  output logic [7:0] hit_count,
  output logic       paddle_hit
);

  localparam logic [9:0] HALF_H  = PADDLE_H >> 1;
  localparam logic [9:0] RESET_Y = 10'd240;

  motion_state_e state_q, state_d;

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [2:0] speed_q, speed_d;
  logic [7:0] hc_q, hc_d;
  logic       ph_q, ph_d;
  logic       toggle_q, toggle_d;

  // Candidate step results, 11-bit signed so a step below zero is visible.
  logic signed [10:0] step, nx, ny;
  logic [9:0]         y_wall;
  logic               dy_wall;
  logic               p1_in, p2_in, p1_cross, p2_cross;
  logic [7:0]         hc_inc;
  logic               speedup;

  function automatic logic [9:0] clamp_y(input logic [10:0] v);
    if (v < {1'b0, WALL_TOP})         clamp_y = WALL_TOP;
    else if (v > {1'b0, WALL_BOTTOM}) clamp_y = WALL_BOTTOM;
    else                              clamp_y = v[9:0];
  endfunction

  function automatic logic [9:0] sat_x(input logic signed [10:0] v);
    if (v < 11'sd0)                         sat_x = 10'd0;
    else if (v > $signed({1'b0, X_LIMIT})) sat_x = X_LIMIT;
    else                                    sat_x = v[9:0];
  endfunction

  function automatic logic [7:0] sat_inc_hits(input logic [7:0] v);
    sat_inc_hits = (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  function automatic logic [2:0] sat_inc_speed(input logic [2:0] v);
    sat_inc_speed = (v >= SPEED_MAX) ? SPEED_MAX : v + 3'd1;
  endfunction

  // ---- Stage p0: state register ----
  always_ff @(posedge clk) begin
    if (reset) state_q <= SERVE1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FROZEN;
    case (game_state_e'(game_state))
      P1_SERVE: state_d = SERVE1;
      P2_SERVE: state_d = SERVE2;
      PLAYING:  state_d = MOVING;
      default:  state_d = FROZEN;
    endcase
  end

  // ---- Stage p0: one-tick motion candidate ----
  always_comb begin
    step = $signed({8'd0, speed_q});
    nx   = dx_q ? $signed({1'b0, x_q}) + step : $signed({1'b0, x_q}) - step;
    ny   = dy_q ? $signed({1'b0, y_q}) + step : $signed({1'b0, y_q}) - step;

    y_wall  = ny[9:0];
    dy_wall = dy_q;
    if (ny < $signed({1'b0, WALL_TOP})) begin
      y_wall  = WALL_TOP;
      dy_wall = 1'b1;
    end else if (ny > $signed({1'b0, WALL_BOTTOM})) begin
      y_wall  = WALL_BOTTOM;
      dy_wall = 1'b0;
    end

    // A paddle can only reflect a ball that starts on the court side of its
    // face and would cross it this tick.
    p1_cross = !dx_q && (x_q >= P1_BOARD_X) && (nx < $signed({1'b0, P1_BOARD_X}));
    p2_cross =  dx_q && (x_q <= P2_BOARD_X) && (nx > $signed({1'b0, P2_BOARD_X}));

    hc_inc  = sat_inc_hits(hc_q);
    speedup = (hc_q != 8'hFF) && (hc_inc != 8'd0) &&
              ((32'(hc_inc) % 32'(HITS_PER_SPEEDUP)) == 32'd0);
  end

  paddle_hit_detect #(.PADDLE_H(PADDLE_H)) u_p1_hit (
    .y        (y_wall),
    .paddle_y (p1_paddle_y),
    .in_range (p1_in)
  );

  paddle_hit_detect #(.PADDLE_H(PADDLE_H)) u_p2_hit (
    .y        (y_wall),
    .paddle_y (p2_paddle_y),
    .in_range (p2_in)
  );

  // ---- Stage p0: next datapath values per state ----
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    speed_d  = speed_q;
    hc_d     = hc_q;
    ph_d     = 1'b0;
    toggle_d = toggle_q;

    case (state_q)
      SERVE1: begin
        if (state_d == MOVING) begin
          // Launch: position holds, vertical direction alternates per serve.
          dy_d     = toggle_q;
          toggle_d = ~toggle_q;
        end else begin
          x_d     = P1_BOARD_X + 10'd1;
          y_d     = clamp_y({1'b0, p1_paddle_y} + {1'b0, HALF_H});
          dx_d    = 1'b1;
          speed_d = SPEED_INIT;
          hc_d    = 8'd0;
        end
      end
      SERVE2: begin
        if (state_d == MOVING) begin
          dy_d     = toggle_q;
          toggle_d = ~toggle_q;
        end else begin
          x_d     = P2_BOARD_X - 10'd1;
          y_d     = clamp_y({1'b0, p2_paddle_y} + {1'b0, HALF_H});
          dx_d    = 1'b0;
          speed_d = SPEED_INIT;
          hc_d    = 8'd0;
        end
      end
      MOVING: begin
        // Leaving MOVING wins over a coincident tick.
        if (state_d == MOVING && tick) begin
          y_d  = y_wall;
          dy_d = dy_wall;
          if (p1_cross && p1_in) begin
            x_d  = P1_BOARD_X;
            dx_d = 1'b1;
            ph_d = 1'b1;
            hc_d = hc_inc;
            if (speedup) speed_d = sat_inc_speed(speed_q);
          end else if (p2_cross && p2_in) begin
            x_d  = P2_BOARD_X;
            dx_d = 1'b0;
            ph_d = 1'b1;
            hc_d = hc_inc;
            if (speedup) speed_d = sat_inc_speed(speed_q);
          end else begin
            x_d = sat_x(nx);
          end
        end
      end
      default: ;
    endcase
  end

  // ---- Stage p1: registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= P1_BOARD_X + 10'd1;
      y_q      <= RESET_Y;
      dx_q     <= 1'b1;
      dy_q     <= 1'b0;
      speed_q  <= SPEED_INIT;
      hc_q     <= 8'd0;
      ph_q     <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      speed_q  <= speed_d;
      hc_q     <= hc_d;
      ph_q     <= ph_d;
      toggle_q <= toggle_d;
    end
  end

  assign ball_x     = x_q;
  assign ball_y     = y_q;
  assign ball_dx    = dx_q;
  assign ball_dy    = dy_q;
  assign speed      = speed_q;
  assign hit_count  = hc_q;
  assign paddle_hit = ph_q;

endmodule
